// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
//   Shared definitions for the stepper motion blocks. The move-state encoding
//   is common to the step generator and the phase sequencer. The sequencer
//   decodes these values directly, so keep them stable.
// -----------------------------------------------------------------------------
package stepper_pkg;

  localparam logic [1:0] STEPPER_IDLE   = 2'd0;
  localparam logic [1:0] STEPPER_RUN    = 2'd1;
  localparam logic [1:0] STEPPER_FINISH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = STEPPER_IDLE,
    ST_RUN    = STEPPER_RUN,
    ST_FINISH = STEPPER_FINISH
  } stepper_state_t;

endpackage

// File: rtl/stepper_interval_timer.sv
// -----------------------------------------------------------------------------
// stepper_interval_timer
//   Loadable-period up-counter that measures the spacing between step strobes.
//   tick is high in the cycle where the count reaches period-1. The counter then
//   wraps to 0, so consecutive ticks are exactly 'period' clocks apart.
//   A load restarts the count from 0 with a new period. A load takes
//   precedence over the wrap, so the owner can reprogram the period in the
//   same cycle as a tick.
//
// Ports
//   clock_clk    in   1         system clock
//   reset_low    in   1         asynchronous active-low reset
//   run          in   1         count enable (tick is suppressed when low)
//   load         in   1         restart count at 0 and take load_period
//   load_period  in   PERIOD_W  new interval length in clocks (>= 1)
//   period       out  PERIOD_W  interval currently being timed
//   tick         out  1         interval elapsed this cycle
// -----------------------------------------------------------------------------
module stepper_interval_timer #(
  parameter int PERIOD_W = 20
) (
  input  logic                clock_clk,
  input  logic                reset_low,
  input  logic                run,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_period,
  output logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] count;

  assign tick = run && (count == (period - P_ONE));

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      count  <= '0;
      period <= '0;
    end else if (load) begin
      count  <= '0;
      period <= load_period;
    end else if (tick) begin
      count  <= '0;
    end else if (run) begin
      count  <= count + P_ONE;
    end
  end

endmodule

// File: rtl/stepper_step_gen.sv
// -----------------------------------------------------------------------------
// stepper_step_gen
//   Trapezoidal-profile step/direction generator for the phase sequencer.
//   The block accepts a move (step count + direction) over valid/ready. It
//   then emits one-cycle step strobes. The interval between strobes starts at
//   START_PERIOD and shrinks by ACCEL_STEP per step down to MIN_PERIOD. It
//   cruises at that interval and then grows back, so the final interval is
//   START_PERIOD again when the ramp has room to complete.
//   'ramp' counts how many accelerating steps are banked. Deceleration starts
//   once the steps left are no more than the banked ramp. An abort shortens
//   the move to what is needed to unwind the ramp. The absolute signed
//   position is also kept here.
//
// Ports
//   clock_clk   in   1        system clock
//   reset_low   in   1        asynchronous active-low reset
//   cmd_valid   in   1        move command present
//   cmd_ready   out  1        command can be accepted (IDLE only)
//   cmd_steps   in   STEP_W   steps to issue (unsigned, 0 = empty move)
//   cmd_dir     in   1        1 = forward (+1), 0 = reverse (-1)
//   abort       in   1        ramped stop of the current move
//   pos_clear   in   1        synchronous zero of position
//   step_pulse  out  1        one-cycle step strobe
//   step_dir    out  1        direction of current move
//   busy        out  1        move in progress
//   done        out  1        one-cycle end-of-move pulse
//   position    out  POS_W    signed absolute step count (wraps)
// -----------------------------------------------------------------------------
module stepper_step_gen
  import stepper_pkg::*;
#(
  parameter int STEP_W       = 16,
  parameter int POS_W        = 32,
  parameter int PERIOD_W     = 20,
  parameter int START_PERIOD = 50000,
  parameter int MIN_PERIOD   = 5000,
  parameter int ACCEL_STEP   = 500
) (
  input  logic                    clock_clk,
  input  logic                    reset_low,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    cmd_dir,
  input  logic                    abort,
  input  logic                    pos_clear,
  output logic                    step_pulse,
  output logic                    step_dir,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  localparam logic [PERIOD_W-1:0]   START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0]   MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0]   ACCEL_P = PERIOD_W'(ACCEL_STEP);
  localparam logic [PERIOD_W:0]     START_X = (PERIOD_W+1)'(START_PERIOD);
  localparam logic [PERIOD_W:0]     MIN_X   = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]     ACCEL_X = (PERIOD_W+1)'(ACCEL_STEP);
  localparam logic [STEP_W-1:0]     S_ONE   = STEP_W'(1);
  localparam logic [STEP_W:0]       S_ONE_X = (STEP_W+1)'(1);
  localparam logic signed [POS_W-1:0] POS_FWD = POS_W'(1);
  localparam logic signed [POS_W-1:0] POS_REV = POS_W'(-1);

  // Period plus one acceleration increment, capped at START_PERIOD.
  // The sum is one bit wider than the period so it cannot wrap.
  function automatic logic [PERIOD_W-1:0] sat_slow(input logic [PERIOD_W-1:0] p);
    logic [PERIOD_W:0] sum;
    sum = {1'b0, p} + ACCEL_X;
    if (sum >= START_X) return START_P;
    return sum[PERIOD_W-1:0];
  endfunction

  // Period minus one acceleration increment, floored at MIN_PERIOD. The
  // floor test is done before subtracting so the period never underflows.
  function automatic logic [PERIOD_W-1:0] sat_fast(input logic [PERIOD_W-1:0] p);
    if ({1'b0, p} <= (MIN_X + ACCEL_X)) return MIN_P;
    return p - ACCEL_P;
  endfunction

  // Limit a step count to ramp+1: the steps needed to finish the current
  // deceleration. ramp+1 is formed one bit wider so it cannot overflow.
  function automatic logic [STEP_W-1:0] clamp_to_ramp(input logic [STEP_W-1:0] val,
                                                      input logic [STEP_W-1:0] rmp);
    logic [STEP_W:0] lim;
    lim = {1'b0, rmp} + S_ONE_X;
    if ({1'b0, val} > lim) return lim[STEP_W-1:0];
    return val;
  endfunction

  stepper_state_t      state;
  logic [STEP_W-1:0]   remaining;
  logic [STEP_W-1:0]   ramp;
  logic [PERIOD_W-1:0] period;
  logic                tick;
  logic                running;
  logic                accept;
  logic                timer_load;
  logic [PERIOD_W-1:0] timer_load_val;

  // Profile decision for the step issued this cycle.
  logic [STEP_W-1:0]   r_dec;
  logic [STEP_W-1:0]   r_step;
  logic                r_last;
  logic [PERIOD_W-1:0] next_period;
  logic [STEP_W-1:0]   next_ramp;

  assign running    = (state == ST_RUN);
  assign accept     = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign step_pulse = tick;

  // Every step reloads the timer with the next interval. The reload also
  // restarts the count, which is what makes a changed period take effect
  // immediately.
  assign timer_load     = accept || tick;
  assign timer_load_val = accept ? START_P : next_period;

  stepper_interval_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clock_clk   (clock_clk),
    .reset_low   (reset_low),
    .run         (running),
    .load        (timer_load),
    .load_period (timer_load_val),
    .period      (period),
    .tick        (tick)
  );

  // If an abort coincides with a step, the step still counts. The shortened
  // remainder then decides whether this step accelerates, cruises or
  // decelerates.
  always_comb begin
    r_dec       = remaining - S_ONE;
    r_step      = abort ? clamp_to_ramp(r_dec, ramp) : r_dec;
    r_last      = (r_step == '0);
    next_period = period;
    next_ramp   = ramp;
    if (!r_last) begin
      if (r_step <= ramp) begin
        next_period = sat_slow(period);
        next_ramp   = ramp - S_ONE;
      end else if (period > MIN_P) begin
        next_period = sat_fast(period);
        next_ramp   = ramp + S_ONE;
      end
    end
  end

  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      step_dir  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      ramp      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            remaining <= cmd_steps;
            ramp      <= '0;
            step_dir  <= cmd_dir;
            cmd_ready <= 1'b0;
            if (cmd_steps != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              // An empty move still reports completion.
              state <= ST_FINISH;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (tick) begin
            remaining <= r_step;
            ramp      <= next_ramp;
            if (r_last) begin
              state <= ST_FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else if (abort) begin
            remaining <= clamp_to_ramp(remaining, ramp);
          end
        end
        ST_FINISH: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // A clear outranks a simultaneous step, so that step is not counted.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      position <= '0;
    end else if (pos_clear) begin
      position <= '0;
    end else if (tick) begin
      position <= position + (step_dir ? POS_FWD : POS_REV);
    end
  end

endmodule

// File: tb/tb_stepper_step_gen.sv
module tb_stepper_step_gen;

  localparam int STEP_W = 16;
  localparam int POS_W  = 32;
  localparam int PER_W  = 20;
  localparam int STARTP = 10;
  localparam int MINP   = 4;
  localparam int ACC    = 2;

  logic                    clock_clk = 1'b0;
  logic                    reset_low = 1'b0;
  logic                    cmd_valid = 1'b0;
  logic [STEP_W-1:0]       cmd_steps = '0;
  logic                    cmd_dir   = 1'b0;
  logic                    abort     = 1'b0;
  logic                    pos_clear = 1'b0;
  logic                    cmd_ready;
  logic                    step_pulse;
  logic                    step_dir;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] position;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Expected move: acceptance cycle, absolute pulse cycles, done cycle.
  int  m_a     = -100;
  int  m_done  = -100;
  int  m_steps = 0;
  bit  m_dir   = 1'b0;
  int  m_pulses[$];
  int  plan_gaps[$];
  logic signed [POS_W-1:0] exp_pos = '0;
  bit  exp_dir = 1'b0;
  bit  ep, ed, eb, er;
  int  act_pulses[$];
  int  act_a = 0;

  stepper_step_gen #(
    .STEP_W       (STEP_W),
    .POS_W        (POS_W),
    .PERIOD_W     (PER_W),
    .START_PERIOD (STARTP),
    .MIN_PERIOD   (MINP),
    .ACCEL_STEP   (ACC)
  ) dut (
    .clock_clk  (clock_clk),
    .reset_low  (reset_low),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .pos_clear  (pos_clear),
    .step_pulse (step_pulse),
    .step_dir   (step_dir),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  always #5 clock_clk = ~clock_clk;
  always @(posedge clock_clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Step-level profile: list of intervals for a move, with an optional abort
  // at cycle offset ab_off after acceptance (-1 = none).
  function automatic void plan(input int steps, input int ab_off);
    int period, rmp, rem, t, r;
    plan_gaps.delete();
    period = STARTP; rmp = 0; rem = steps; t = 0;
    while (rem > 0) begin
      if (ab_off > t && ab_off < t + period && rem > rmp + 1) rem = rmp + 1;
      t += period;
      plan_gaps.push_back(period);
      r = rem - 1;
      if (ab_off == t && r > rmp + 1) r = rmp + 1;
      rem = r;
      if (r > 0) begin
        if (r <= rmp) begin
          period = (period + ACC > STARTP) ? STARTP : period + ACC;
          rmp--;
        end else if (period > MINP) begin
          period = (period - ACC < MINP) ? MINP : period - ACC;
          rmp++;
        end
      end
    end
  endfunction

  always @(negedge clock_clk) begin
    if (chk_en) begin
      ep = 1'b0;
      foreach (m_pulses[i]) if (m_pulses[i] == cyc) ep = 1'b1;
      ed = (cyc == m_done);
      eb = (m_steps != 0) && (cyc > m_a) && (cyc < m_done);
      er = !((cyc > m_a) && (cyc <= m_done));
      check("step_pulse", step_pulse, ep);
      check("done", done, ed);
      check("busy", busy, eb);
      check("cmd_ready", cmd_ready, er);
      check("position", position, exp_pos);
      check("step_dir", step_dir, exp_dir);
      if (step_pulse === 1'b1) act_pulses.push_back(cyc);
      if (pos_clear) exp_pos = '0;
      else if (ep) exp_pos = exp_dir ? exp_pos + 1 : exp_pos - 1;
      if (cyc == m_a) exp_dir = m_dir;
    end
  end

  task automatic start_cmd(input int steps, input bit dir, input int ab_off);
    int t;
    plan(steps, ab_off);
    @(posedge clock_clk); #1;
    t = cyc;
    m_pulses.delete();
    foreach (plan_gaps[i]) begin t += plan_gaps[i]; m_pulses.push_back(t); end
    m_done  = (steps == 0) ? cyc + 1 : t + 1;
    m_steps = steps;
    m_dir   = dir;
    m_a     = cyc;
    act_a   = cyc;
    act_pulses.delete();
    cmd_valid = 1'b1;
    cmd_steps = steps[STEP_W-1:0];
    cmd_dir   = dir;
    abort     = (ab_off == 0);
  endtask

  task automatic issue(input int steps, input bit dir, input int ab_off,
                       input int clr_k, input bit poke);
    start_cmd(steps, dir, ab_off);
    while (cyc <= m_done) begin
      @(posedge clock_clk); #1;
      cmd_valid = poke && (cyc >= m_a + 3) && (cyc <= m_a + 5);
      cmd_steps = poke ? STEP_W'(7) : '0;
      abort     = (ab_off > 0) && (cyc == m_a + ab_off);
      pos_clear = (clr_k > 0) && (clr_k <= m_pulses.size()) && (cyc == m_pulses[clr_k-1]);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    pos_clear = 1'b0;
  endtask

  task automatic check_gaps(input string name, input int exp[$]);
    int prev;
    prev = act_a;
    check({name, "_count"}, act_pulses.size(), exp.size());
    foreach (exp[i]) begin
      if (i < act_pulses.size()) begin
        check(name, act_pulses[i] - prev, exp[i]);
        prev = act_pulses[i];
      end
    end
  endtask

  initial begin
    int exp_g[$];
    int seen;

    // Power-up reset state.
    repeat (3) @(posedge clock_clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_pulse", step_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", step_dir, 0);
    check("rst_pos", position, 0);
    #2 reset_low = 1'b1;
    chk_en = 1'b1;

    // Reset in the middle of a move.
    start_cmd(10, 1'b1, -1);
    @(posedge clock_clk); #1;
    cmd_valid = 1'b0;
    repeat (13) @(posedge clock_clk);
    #1;
    chk_en = 1'b0;
    check("pre_rst_pos", position, 1);
    check("pre_rst_dir", step_dir, 1);
    check("pre_rst_busy", busy, 1);
    #1 reset_low = 1'b0;
    #1;
    check("async_rst_ready", cmd_ready, 1);
    check("async_rst_pulse", step_pulse, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_dir", step_dir, 0);
    check("async_rst_pos", position, 0);
    seen = 0;
    repeat (30) begin
      @(negedge clock_clk);
      if (step_pulse !== 1'b0) seen++;
    end
    check("pulses_in_reset", seen, 0);
    #2 reset_low = 1'b1;
    m_pulses.delete();
    m_a = -100; m_done = -100; m_steps = 0;
    exp_pos = '0; exp_dir = 1'b0;
    chk_en = 1'b1;
    @(negedge clock_clk);
    check("ready_after_rst", cmd_ready, 1);

    // Full trapezoid.
    issue(10, 1'b1, -1, 0, 1'b0);
    exp_g = {10, 8, 6, 4, 4, 4, 4, 6, 8, 10};
    check_gaps("gaps_10", exp_g);
    if (act_pulses.size() > 0) check("span_10", act_pulses[act_pulses.size()-1] - act_a, 64);
    check("pos_after_10", position, 10);

    // Short reverse move, abort while idle is ignored.
    issue(3, 1'b0, 0, 0, 1'b0);
    exp_g = {10, 8, 10};
    check_gaps("gaps_3", exp_g);
    check("pos_after_3", position, 7);

    // Empty move.
    issue(0, 1'b1, -1, 0, 1'b0);
    exp_g = {};
    check_gaps("gaps_0", exp_g);
    check("pos_after_0", position, 7);

    // Long move aborted on the third step.
    issue(100, 1'b1, 24, 0, 1'b0);
    exp_g = {10, 8, 6, 4, 6, 8};
    check_gaps("gaps_abort", exp_g);
    check("pos_after_abort", position, 13);

    // Abort between steps.
    issue(10, 1'b0, 12, 0, 1'b0);
    exp_g = {10, 8, 10};
    check_gaps("gaps_abort_mid", exp_g);
    check("pos_after_abort_mid", position, 10);

    // Standalone clear, then clear colliding with the sixth step, and a
    // command offered while busy.
    @(posedge clock_clk); #1;
    pos_clear = 1'b1;
    @(posedge clock_clk); #1;
    pos_clear = 1'b0;
    check("pos_cleared", position, 0);
    issue(6, 1'b1, -1, 6, 1'b1);
    exp_g = {10, 8, 6, 4, 6, 8};
    check_gaps("gaps_clear", exp_g);
    check("pos_after_clear_step", position, 0);

    repeat (3) @(posedge clock_clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
